serial_alu_engine: RTL and testbench



---
 rtl/serial_alu_engine.sv | 149 ++++++++++++++
 tb/tb_serial_alu_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_engine.sv
// serial_alu_engine: serial frame in (A then B, MSB first), WIDTH-bit ALU op, serial result out with valid/ready; define SERIAL_ALU_ENGINE_FLAGS_EN to append carry and zero flags to the output frame
module serial_alu_engine #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       start_i,
    input  logic [2:0] ctl_i,
    input  logic       in_valid_i,
    input  logic       in_data_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic       out_data_o,
    output logic       out_last_o,
    output logic       done_o,
    output logic       busy_o,
    output logic [1:0] state_o
);
`ifdef SERIAL_ALU_ENGINE_FLAGS_EN
    localparam int OW = WIDTH + 2;
`else
    localparam int OW = WIDTH;
`endif
    localparam int CW = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IN   = 2'd1,
        S_CMP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_sreg;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_ctl;
    logic [OW-1:0]        r_obuf;
    logic                 r_done;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [SHAMT_W-1:0]   w_sh;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_r;
    logic [OW-1:0]        w_frame;
    logic                 w_in_acc;
    logic                 w_out_acc;
    logic                 w_in_last;
    logic                 w_out_last;

    assign w_a        = r_sreg[2*WIDTH-1:WIDTH];
    assign w_b        = r_sreg[WIDTH-1:0];
    assign w_sh       = w_b[SHAMT_W-1:0];
    assign w_in_acc   = en_i && in_valid_i && r_state == S_IN;
    assign w_out_acc  = en_i && out_ready_i && r_state == S_OUT;
    assign w_in_last  = r_cnt == CW'(2 * WIDTH - 1);
    assign w_out_last = r_cnt == CW'(OW - 1);

`ifdef SERIAL_ALU_ENGINE_FLAGS_EN
    logic w_carry;
    logic w_c;
    assign {w_carry, w_sum} = {1'b0, w_a} + {1'b0, w_b};
    assign w_c     = r_ctl == 3'b000 ? w_carry : r_ctl == 3'b001 ? (w_a < w_b) : 1'b0;
    assign w_frame = {w_r, w_c, w_r == '0};
`else
    assign w_sum   = w_a + w_b;
    assign w_frame = w_r;
`endif

    // ALU operation on the captured operands
    always_comb begin
        w_r = w_a;
        case (r_ctl)
            3'b000:  w_r = w_sum;
            3'b001:  w_r = w_a - w_b;
            3'b010:  w_r = w_a & w_b;
            3'b011:  w_r = w_a | w_b;
            3'b100:  w_r = w_a ^ w_b;
            3'b101:  w_r = w_a << w_sh;
            3'b110:  w_r = w_a >> w_sh;
            default: w_r = w_a;
        endcase
    end

    // Next-state logic; en_i low holds the current state
    always_comb begin
        w_next = r_state;
        if (en_i) begin
            case (r_state)
                S_IDLE:  w_next = start_i ? S_IN : S_IDLE;
                S_IN:    w_next = (in_valid_i && w_in_last) ? S_CMP : S_IN;
                S_CMP:   w_next = S_OUT;
                default: w_next = (out_ready_i && w_out_last) ? S_IDLE : S_OUT;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Datapath: operand capture, result load and output shifting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_ctl  <= '0;
            r_obuf <= '0;
            r_done <= 1'b0;
        end else if (en_i) begin
            r_done <= w_out_acc && w_out_last;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ctl <= ctl_i;
                        r_cnt <= '0;
                    end
                end
                S_IN: begin
                    if (w_in_acc) begin
                        r_sreg <= {r_sreg[2*WIDTH-2:0], in_data_i};
                        r_cnt  <= w_in_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_CMP: begin
                    r_obuf <= w_frame;
                    r_cnt  <= '0;
                end
                default: begin
                    if (w_out_acc) begin
                        r_obuf <= r_obuf << 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid_o = r_state == S_OUT;
    assign out_data_o  = r_state == S_OUT && r_obuf[OW-1];
    assign out_last_o  = r_state == S_OUT && w_out_last;
    assign done_o      = r_done;
    assign busy_o      = r_state != S_IDLE;
    assign state_o     = r_state;
endmodule

// File: tb/tb_serial_alu_engine.sv
// tb_serial_alu_engine: random and directed frames checked against an arithmetic reference model
module tb_serial_alu_engine;
    localparam int W  = 8;
    localparam int SH = $clog2(W);
`ifdef SERIAL_ALU_ENGINE_FLAGS_EN
    localparam int OW = W + 2;
`else
    localparam int OW = W;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b1;
    logic       start_i = 1'b0;
    logic [2:0] ctl_i = 3'd0;
    logic       in_valid_i = 1'b0;
    logic       in_data_i = 1'b0;
    logic       out_ready_i = 1'b0;
    logic       out_valid_o, out_data_o, out_last_o, done_o, busy_o;
    logic [1:0] state_o;
    int         total = 0;
    int         bad = 0;

    serial_alu_engine #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .start_i(start_i), .ctl_i(ctl_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .done_o(done_o), .busy_o(busy_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a8, input logic [W-1:0] b8);
        longint unsigned a = 64'(a8);
        longint unsigned b = 64'(b8);
        longint unsigned m = (64'd1 << W) - 1;
        longint unsigned s = b & ((64'd1 << SH) - 1);
        longint unsigned r;
        longint unsigned c = 0;
        case (op)
            3'd0: begin r = a + b; c = (r > m) ? 1 : 0; end
            3'd1: begin r = a - b; c = (a < b) ? 1 : 0; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << s;
            3'd6: r = a >> s;
            default: r = a;
        endcase
        r = r & m;
`ifdef SERIAL_ALU_ENGINE_FLAGS_EN
        return (r << 2) | (c << 1) | ((r == 0) ? 64'd1 : 64'd0);
`else
        return r;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap_pct, input int stall_pct, input int stall_at,
                         input int freeze, input bit stray);
        logic [2*W-1:0] din = {a, b};
        logic [63:0]    got = '0;
        logic [63:0]    exp = model(op, a, b);
        int             cyc = 0, gaps = 0, n = 0, idx = 2 * W - 1, held = 0;
        bit             prev_ok = 1'b1, prev_bit = 1'b0, rdy;
        start_i = 1'b1;
        ctl_i = op;
        step();
        start_i = 1'b0;
        ctl_i = 3'($urandom);
        cyc = 1;
        chk("start_state", 64'(state_o), 64'd1);
        chk("done_pulse", 64'(done_o), 64'd0);
        while (idx >= 0) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid_i = 1'b0;
                in_data_i = 1'($urandom);
                gaps++;
            end else begin
                in_valid_i = 1'b1;
                in_data_i = din[idx];
                idx--;
            end
            start_i = stray ? 1'($urandom) : 1'b0;
            out_ready_i = 1'($urandom);
            step();
            cyc++;
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        out_ready_i = 1'b0;
        if (freeze > 0) begin
            en_i = 1'b0;
            for (int k = 0; k < freeze; k++) begin
                in_valid_i = 1'($urandom);
                out_ready_i = 1'($urandom);
                step();
                cyc++;
                chk("freeze_state", 64'(state_o), 64'd2);
                chk("freeze_valid", 64'(out_valid_o), 64'd0);
            end
            in_valid_i = 1'b0;
            out_ready_i = 1'b0;
            en_i = 1'b1;
        end
        while (!out_valid_o && cyc < 300) begin
            step();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(2 * W + 2 + gaps + freeze));
        while (n < OW && cyc < 600) begin
            if (!prev_ok) chk("hold_bit", 64'(out_data_o), 64'(prev_bit));
            if (stall_at >= 0) rdy = !(n == stall_at && held < 3);
            else rdy = int'($urandom_range(99)) >= stall_pct;
            if (!rdy) held++;
            out_ready_i = rdy;
            start_i = stray ? 1'($urandom) : 1'b0;
            in_valid_i = 1'($urandom);
            if (rdy) begin
                got = {got[62:0], out_data_o};
                chk("last_flag", 64'(out_last_o), 64'(n == OW - 1));
                n++;
            end
            prev_ok = rdy;
            prev_bit = out_data_o;
            step();
            cyc++;
        end
        out_ready_i = 1'b0;
        start_i = 1'b0;
        in_valid_i = 1'b0;
        chk("result", got, exp);
        chk("done", 64'(done_o), 64'd1);
        chk("end_state", 64'(state_o), 64'd0);
        chk("end_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_outs", 64'({out_valid_o, out_data_o, out_last_o, done_o, busy_o}), 64'd0);
        rst_ni = 1'b1;
        step();
        start_i = 1'b1;
        ctl_i = 3'd0;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid_i = 1'b1;
            in_data_i = 1'($urandom);
            step();
        end
        in_valid_i = 1'b0;
        chk("pre_rst_state", 64'(state_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_state", 64'(state_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("abort_valid", 64'(out_valid_o), 64'd0);
        frame(3'd0, 8'h12, 8'h34, 0, 0, -1, 0, 0);
        frame(3'd0, 8'hF0, 8'h20, 0, 0, -1, 0, 0);
        frame(3'd1, 8'h05, 8'h05, 0, 0, -1, 0, 0);
        frame(3'd5, 8'h81, 8'h09, 0, 0, -1, 0, 0);
        frame(3'd4, 8'hAA, 8'h0F, 0, 0, 4, 0, 0);
        step();
        chk("done_single", 64'(done_o), 64'd0);
        frame(3'd2, 8'h3C, 8'h5A, 30, 0, -1, 0, 1);
        frame(3'd6, 8'h80, 8'h03, 0, 0, -1, 4, 0);
        for (int t = 0; t < 40; t++)
            frame(3'($urandom), 8'($urandom), 8'($urandom), 25, 30, -1, (t % 7 == 0) ? 2 : 0, t[0]);
        step();
        chk("final_done", 64'(done_o), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
